// File: rtl/hazard_pkg.sv
// Shared constants for the P5 hazard unit: Tuse/Tnew codes and forwarding-mux encodings.
package hazard_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] T_LW   = 2'd2;
    localparam logic [1:0] T_ALU  = 2'd1;
    localparam logic [1:0] T_LINK = 2'd0;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2,
        FWD_E  = 2'd3
    } fwd_e;

endpackage

// File: rtl/hazard_if.sv
// Decoder <-> hazard unit interface: D-stage decode results in, stall and forward selects out.
interface hazard_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned T_W   = 2
);
    logic [REG_W-1:0] rs_D;
    logic [REG_W-1:0] rt_D;
    logic [REG_W-1:0] A3_D;
    logic [T_W-1:0]   Tuse_rs_D;
    logic [T_W-1:0]   Tuse_rt_D;
    logic [T_W-1:0]   Tnew_D;
    logic             stall;
    logic [1:0]       fwd_rs_D;
    logic [1:0]       fwd_rt_D;
    logic [1:0]       fwd_rs_E;
    logic [1:0]       fwd_rt_E;
    logic             fwd_rt_M;

    modport master (
        output rs_D, rt_D, A3_D, Tuse_rs_D, Tuse_rt_D, Tnew_D,
        input  stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
    );

    modport slave (
        input  rs_D, rt_D, A3_D, Tuse_rs_D, Tuse_rt_D, Tnew_D,
        output stall, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Nearest-stage-first forwarding selector for one source operand.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned T_W   = 2,
    parameter bit          USE_E = 1'b1
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] e_a3,
    input  logic [T_W-1:0]   e_tnew,
    input  logic [REG_W-1:0] m_a3,
    input  logic [T_W-1:0]   m_tnew,
    input  logic [REG_W-1:0] w_a3,
    output fwd_e             sel
);
    logic src_nz;
    logic e_match;
    logic m_match;
    logic w_match;

    assign src_nz  = (src != '0);
    assign e_match = USE_E && src_nz && (src == e_a3);
    assign m_match = src_nz && (src == m_a3);
    assign w_match = src_nz && (src == w_a3);

    // For D-stage consumers a matching producer that is not ready yet hides
    // older producers of the same register, so a stale value is never picked.
    always_comb begin
        sel = FWD_RF;
        if (e_match) begin
            sel = (e_tnew == '0) ? FWD_E : FWD_RF;
        end else if (m_match && (m_tnew == '0)) begin
            sel = FWD_M;
        end else if (m_match && USE_E) begin
            sel = FWD_RF;
        end else if (w_match) begin
            sel = FWD_W;
        end
    end
endmodule

// File: rtl/hazard_unit.sv
// P5 hazard unit: shadow E/M/W destination pipeline, stall generation and forward selects.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned T_W   = 2
) (
    input logic   clk,
    input logic   reset_n,
    hazard_if.slave hz
);
    logic [REG_W-1:0] e_rs, e_rt, e_a3;
    logic [T_W-1:0]   e_tnew;
    logic [REG_W-1:0] m_rt, m_a3;
    logic [T_W-1:0]   m_tnew;
    logic [REG_W-1:0] w_a3;

    logic stall_rs;
    logic stall_rt;
    fwd_e sel_rs_D, sel_rt_D, sel_rs_E, sel_rt_E, sel_rt_M;

    function automatic logic needs_stall(
        input logic [REG_W-1:0] src,
        input logic [T_W-1:0]   tuse,
        input logic [REG_W-1:0] ea3,
        input logic [T_W-1:0]   etnew,
        input logic [REG_W-1:0] ma3,
        input logic [T_W-1:0]   mtnew
    );
        return (src != '0) && (tuse != TUSE_NONE) &&
               (((src == ea3) && (etnew > tuse)) || ((src == ma3) && (mtnew > tuse)));
    endfunction

    always_comb begin
        stall_rs = needs_stall(hz.rs_D, hz.Tuse_rs_D, e_a3, e_tnew, m_a3, m_tnew);
        stall_rt = needs_stall(hz.rt_D, hz.Tuse_rt_D, e_a3, e_tnew, m_a3, m_tnew);
    end

    assign hz.stall = stall_rs | stall_rt;

    // M.rs and W.rs/rt/Tnew are never consumed, so only the live fields are kept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_rs   <= '0;
            e_rt   <= '0;
            e_a3   <= '0;
            e_tnew <= '0;
            m_rt   <= '0;
            m_a3   <= '0;
            m_tnew <= '0;
            w_a3   <= '0;
        end else begin
            if (hz.stall) begin
                e_rs   <= '0;
                e_rt   <= '0;
                e_a3   <= '0;
                e_tnew <= '0;
            end else begin
                e_rs   <= hz.rs_D;
                e_rt   <= hz.rt_D;
                e_a3   <= hz.A3_D;
                e_tnew <= hz.Tnew_D;
            end
            m_rt   <= e_rt;
            m_a3   <= e_a3;
            m_tnew <= (e_tnew == '0) ? '0 : e_tnew - 1'b1;
            w_a3   <= m_a3;
        end
    end

    hazard_fwd_sel #(.REG_W(REG_W), .T_W(T_W), .USE_E(1'b1)) u_sel_rs_D (
        .src(hz.rs_D), .e_a3(e_a3), .e_tnew(e_tnew),
        .m_a3(m_a3), .m_tnew(m_tnew), .w_a3(w_a3), .sel(sel_rs_D)
    );

    hazard_fwd_sel #(.REG_W(REG_W), .T_W(T_W), .USE_E(1'b1)) u_sel_rt_D (
        .src(hz.rt_D), .e_a3(e_a3), .e_tnew(e_tnew),
        .m_a3(m_a3), .m_tnew(m_tnew), .w_a3(w_a3), .sel(sel_rt_D)
    );

    hazard_fwd_sel #(.REG_W(REG_W), .T_W(T_W), .USE_E(1'b0)) u_sel_rs_E (
        .src(e_rs), .e_a3('0), .e_tnew('0),
        .m_a3(m_a3), .m_tnew(m_tnew), .w_a3(w_a3), .sel(sel_rs_E)
    );

    hazard_fwd_sel #(.REG_W(REG_W), .T_W(T_W), .USE_E(1'b0)) u_sel_rt_E (
        .src(e_rt), .e_a3('0), .e_tnew('0),
        .m_a3(m_a3), .m_tnew(m_tnew), .w_a3(w_a3), .sel(sel_rt_E)
    );

    // Store data in M can only be refreshed from W, so the M level is tied off too.
    hazard_fwd_sel #(.REG_W(REG_W), .T_W(T_W), .USE_E(1'b0)) u_sel_rt_M (
        .src(m_rt), .e_a3('0), .e_tnew('0),
        .m_a3('0), .m_tnew('0), .w_a3(w_a3), .sel(sel_rt_M)
    );

    assign hz.fwd_rs_D = sel_rs_D;
    assign hz.fwd_rt_D = sel_rt_D;
    assign hz.fwd_rs_E = sel_rs_E;
    assign hz.fwd_rt_E = sel_rt_E;
    assign hz.fwd_rt_M = (sel_rt_M == FWD_W);
endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit using hand-computed expectations.
module tb_hazard_unit;
    import hazard_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    hazard_if #(.REG_W(5), .T_W(2)) hz ();

    hazard_unit #(.REG_W(5), .T_W(2)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .hz(hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] a3,
                         input logic [1:0] tu_rs, input logic [1:0] tu_rt, input logic [1:0] tnew);
        hz.rs_D      = rs;
        hz.rt_D      = rt;
        hz.A3_D      = a3;
        hz.Tuse_rs_D = tu_rs;
        hz.Tuse_rt_D = tu_rt;
        hz.Tnew_D    = tnew;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        set_d(5'd0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, T_LINK);
        repeat (3) step();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        set_d(5'd0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, T_LINK);
        #12;
        chk("reset_stall", {1'b0, hz.stall}, 2'd0);
        chk("reset_fwd_rs_D", hz.fwd_rs_D, 2'd0);
        chk("reset_fwd_rt_M", {1'b0, hz.fwd_rt_M}, 2'd0);
        reset_n = 1'b1;
        step();

        // lw $1 then addu rs=1 (Tuse 1)
        set_d(5'd29, 5'd0, 5'd1, 2'd1, TUSE_NONE, T_LW);
        step();
        set_d(5'd1, 5'd2, 5'd3, 2'd1, 2'd1, T_ALU);
        chk("lw_use_c0_stall", {1'b0, hz.stall}, 2'd1);
        chk("lw_use_c0_fwd_blocked", hz.fwd_rs_D, 2'd0);
        step();
        chk("lw_use_c1_stall", {1'b0, hz.stall}, 2'd0);
        chk("lw_use_c1_fwd_blocked", hz.fwd_rs_D, 2'd0);
        step();
        set_d(5'd0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, T_LINK);
        chk("lw_use_c2_fwd_rs_E", hz.fwd_rs_E, 2'd1);
        chk("lw_use_c2_fwd_rt_E", hz.fwd_rt_E, 2'd0);
        flush();

        // addu $4 then beq rs=4 (Tuse 0)
        set_d(5'd8, 5'd9, 5'd4, 2'd1, 2'd1, T_ALU);
        step();
        set_d(5'd4, 5'd5, 5'd0, 2'd0, 2'd0, T_LINK);
        chk("alu_beq_c0_stall", {1'b0, hz.stall}, 2'd1);
        step();
        chk("alu_beq_c1_stall", {1'b0, hz.stall}, 2'd0);
        chk("alu_beq_c1_fwd_rs_D", hz.fwd_rs_D, 2'd2);
        chk("alu_beq_c1_fwd_rt_D", hz.fwd_rt_D, 2'd0);
        flush();

        // jal then jr $31: E forward, then M forward after saturating Tnew
        set_d(5'd0, 5'd0, 5'd31, TUSE_NONE, TUSE_NONE, T_LINK);
        step();
        set_d(5'd31, 5'd0, 5'd0, 2'd0, TUSE_NONE, T_LINK);
        chk("jal_jr_stall", {1'b0, hz.stall}, 2'd0);
        chk("jal_jr_fwd_rs_D", hz.fwd_rs_D, 2'd3);
        set_d(5'd0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, T_LINK);
        step();
        set_d(5'd31, 5'd0, 5'd0, 2'd0, TUSE_NONE, T_LINK);
        chk("jal_in_M_stall", {1'b0, hz.stall}, 2'd0);
        chk("jal_in_M_fwd_rs_D", hz.fwd_rs_D, 2'd2);
        flush();

        // Two ready producers of $10: nearest (E) wins
        set_d(5'd0, 5'd0, 5'd10, TUSE_NONE, TUSE_NONE, T_LINK);
        step();
        step();
        set_d(5'd0, 5'd10, 5'd0, TUSE_NONE, 2'd0, T_LINK);
        chk("prio_E_over_M", hz.fwd_rt_D, 2'd3);
        flush();

        // lw $2 then sw rt=2 (Tuse 2)
        set_d(5'd29, 5'd0, 5'd2, 2'd1, TUSE_NONE, T_LW);
        step();
        set_d(5'd29, 5'd2, 5'd0, 2'd1, 2'd2, T_LINK);
        chk("lw_sw_stall", {1'b0, hz.stall}, 2'd0);
        chk("lw_sw_fwd_rt_D", hz.fwd_rt_D, 2'd0);
        step();
        set_d(5'd0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, T_LINK);
        chk("lw_sw_E_fwd_rt_E", hz.fwd_rt_E, 2'd0);
        chk("lw_sw_E_fwd_rt_M", {1'b0, hz.fwd_rt_M}, 2'd0);
        step();
        chk("lw_sw_M_fwd_rt_M", {1'b0, hz.fwd_rt_M}, 2'd1);
        flush();

        // Unused operand (Tuse 3) never stalls
        set_d(5'd29, 5'd0, 5'd7, 2'd1, TUSE_NONE, T_LW);
        step();
        set_d(5'd7, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, T_LINK);
        chk("tuse_none_stall", {1'b0, hz.stall}, 2'd0);
        flush();

        // ori $0 then addu rs=0
        set_d(5'd8, 5'd0, 5'd0, 2'd1, TUSE_NONE, T_ALU);
        step();
        set_d(5'd0, 5'd0, 5'd5, 2'd1, 2'd1, T_ALU);
        chk("r0_stall", {1'b0, hz.stall}, 2'd0);
        chk("r0_fwd_rs_D", hz.fwd_rs_D, 2'd0);
        chk("r0_fwd_rt_D", hz.fwd_rt_D, 2'd0);
        chk("r0_fwd_rs_E", hz.fwd_rs_E, 2'd0);
        chk("r0_fwd_rt_M", {1'b0, hz.fwd_rt_M}, 2'd0);
        step();
        set_d(5'd0, 5'd0, 5'd0, TUSE_NONE, TUSE_NONE, T_LINK);
        chk("r0_E_fwd_rs_E", hz.fwd_rs_E, 2'd0);
        chk("r0_E_fwd_rt_E", hz.fwd_rt_E, 2'd0);
        flush();

        // lw $5 in E, addu rs=5 waiting, asynchronous reset mid-cycle
        set_d(5'd29, 5'd0, 5'd5, 2'd1, TUSE_NONE, T_LW);
        step();
        set_d(5'd5, 5'd0, 5'd6, 2'd1, TUSE_NONE, T_ALU);
        chk("rst_pre_stall", {1'b0, hz.stall}, 2'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_stall", {1'b0, hz.stall}, 2'd0);
        chk("rst_mid_fwd_rs_D", hz.fwd_rs_D, 2'd0);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst_post_stall", {1'b0, hz.stall}, 2'd0);
        step();
        chk("rst_post_edge_stall", {1'b0, hz.stall}, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer side of the instruction decoder's hazard interface for the 5-stage P5 pipeline (F/D/E/M/W).
- Each cycle it takes the D-stage decode results (rs, rt, A3, Tuse_rs, Tuse_rt, Tnew).
- It keeps its own shadow pipeline of in-flight destinations and remaining Tnew for E/M/W.
- From these it produces the stall signal and all forwarding-mux selects for D, E and M.

Parameters:
- REG_W, 5, register-index width
- T_W, 2, width of Tuse/Tnew fields

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- rs_D  in  5  D-stage rs index
- rt_D  in  5  D-stage rt index
- A3_D  in  5  D-stage destination (0 = no write)
- Tuse_rs_D  in  2  cycles until rs needed (3 = not used)
- Tuse_rt_D  in  2  cycles until rt needed (3 = not used)
- Tnew_D  in  2  cycles until result ready, counted from entry to E (lw=2, ALU=1, jal/jalr=0)
- stall  out  1  freeze PC and F/D register, insert bubble into D/E
- fwd_rs_D  out  2  D-stage rs select: 0 RF, 1 W, 2 M, 3 E
- fwd_rt_D  out  2  D-stage rt select, same encoding
- fwd_rs_E  out  2  E-stage rs select: 0 pipe, 1 W, 2 M
- fwd_rt_E  out  2  E-stage rt select, same encoding
- fwd_rt_M  out  1  M-stage rt (store data): 0 pipe, 1 W

Behaviour:
- State: one entry per stage E, M, W, each holding {rs, rt, A3, Tnew}. W Tnew is always 0.
- Reset (async, reset_n=0): all entries cleared to a bubble (all fields 0). Effects are immediate:
  - stall=0
  - all fwd_* = 0
  - reset mid-operation discards every in-flight entry.
- Clock edge, stall=0:
  - E <= {rs_D, rt_D, A3_D, Tnew_D}
  - M <= E with Tnew = sat_dec(E.Tnew)
  - W <= M
- Clock edge, stall=1:
  - E <= bubble
  - M and W advance exactly as in the stall=0 case.
- sat_dec(x) = (x==0) ? 0 : x-1. No wrap-around.
- stall is combinational and equals stall_rs | stall_rt. stall_rs is asserted when:
  - rs_D != 0, and
  - Tuse_rs_D != 3, and
  - ((rs_D==E.A3 && E.Tnew > Tuse_rs_D) or (rs_D==M.A3 && M.Tnew > Tuse_rs_D)).
- stall_rt uses the same rule with rt_D and Tuse_rt_D.
- Stall is never generated on a W-stage match.
- Forward priority is nearest stage first. A source qualifies only if A3 matches, A3 != 0, and its Tnew == 0.
  - fwd_x_D: E qualifies -> 3; else M qualifies -> 2; else W matches -> 1; else 0. (W.A3 must be nonzero.)
  - fwd_x_E: compares E.rs/E.rt against M (qualified) -> 2; else W -> 1; else 0.
  - fwd_rt_M: M.rt == W.A3 and W.A3 != 0 -> 1; else 0.
- A matching stage whose Tnew > 0 blocks farther stages from being selected for D-stage forwarding. That stage causes a stall instead; a stale value is never forwarded.
- Register $0 is never stalled on and never forwarded.
- All outputs are combinational from the entries plus the D inputs. There is no latency beyond the shadow-pipeline registers.

Decomposition:
- Shared package hazard_pkg holds:
  - TUSE_NONE=3
  - Tnew constants T_LW=2, T_ALU=1, T_LINK=0
  - forwarding encodings FWD_RF=0, FWD_W=1, FWD_M=2, FWD_E=3
- One natural sub-module, hazard_fwd_sel: a combinational priority selector. Inputs are a source index plus the E/M/W {A3, Tnew}; output is the select code. It is instantiated five times, with the E level disabled for E and M consumers.

Test Plan:
- lw $1 (A3=1, Tnew=2), then addu using rs=1, Tuse_rs=1:
  - cycle 0: stall=1
  - cycle 1: stall=0
  - cycle 2: fwd_rs_E=1 (W)
- addu $4 (Tnew=1), then beq rs=4, Tuse_rs=0:
  - cycle 0: stall=1
  - cycle 1: stall=0 and fwd_rs_D=2 (M)
- jal (A3=31, Tnew=0), then jr rs=31, Tuse_rs=0: stall=0 and fwd_rs_D=3 (E) on the cycle jal occupies E.
- lw $2 (Tnew=2), then sw with rt=2, Tuse_rt=2:
  - no stall
  - when sw reaches M, fwd_rt_M=1
- ori $0 (A3=0), then addu rs=0: stall=0 and all fwd_*=0.
- lw $5 in E with addu rs=5 waiting in D, then reset_n pulsed low mid-cycle: stall drops to 0 immediately. After release, the same addu in D produces no stall.
